// File: rtl/vga_plot_arbiter_if.sv
// Pixel request channel: a requester offers one (x, y, colour) pixel with valid,
// and the arbiter answers with a same-cycle ready when it takes the pixel.
interface vga_plot_arbiter_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int C_W = 3
);
  logic           valid;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [C_W-1:0] colour;
  logic           ready;

  modport master (
    output valid,
    output x,
    output y,
    output colour,
    input  ready
  );

  modport slave (
    input  valid,
    input  x,
    input  y,
    input  colour,
    output ready
  );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Shares the single VGA adapter pixel-write port between two requesters (A, B)
// with round-robin arbitration, and contains a full-screen clear sequencer that
// takes over the port for one whole frame of consecutive writes.
module vga_plot_arbiter #(
  parameter int X_W   = 8,
  parameter int Y_W   = 7,
  parameter int C_W   = 3,
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear_req,
  input  logic [C_W-1:0]       clear_colour,
  output logic                 clear_busy,
  vga_plot_arbiter_if.slave    a,
  vga_plot_arbiter_if.slave    b,
  output logic [X_W-1:0]       vga_x,
  output logic [Y_W-1:0]       vga_y,
  output logic [C_W-1:0]       vga_colour,
  output logic                 vga_plot
);

  localparam logic [X_W-1:0] X_LAST = X_W'(X_MAX);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_MAX);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t         state;
  logic           last_was_b;
  logic [X_W-1:0] cnt_x;
  logic [Y_W-1:0] cnt_y;
  logic [C_W-1:0] clr_colour;

  logic grant_a;
  logic grant_b;
  logic a_in_range;
  logic b_in_range;

  // Round-robin grant: a lone requester always wins; under contention the one
  // not granted last time wins. Nothing is granted in reset or while clearing.
  assign grant_a = !reset && (state == IDLE) && a.valid && (!b.valid || last_was_b);
  assign grant_b = !reset && (state == IDLE) && b.valid && (!a.valid || !last_was_b);

  assign a.ready = grant_a;
  assign b.ready = grant_b;

  // Off-screen pixels are consumed but never reach the adapter.
  assign a_in_range = (a.x <= X_LAST) && (a.y <= Y_LAST);
  assign b_in_range = (b.x <= X_LAST) && (b.y <= Y_LAST);

  // Arbiter/clear FSM with registered adapter outputs; plot is a one-cycle strobe
  // and the coordinate/colour registers hold their value between strobes.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_was_b <= 1'b1;
      cnt_x      <= '0;
      cnt_y      <= '0;
      clr_colour <= '0;
      clear_busy <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      vga_plot <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_a) begin
            last_was_b <= 1'b0;
            if (a_in_range) begin
              vga_x      <= a.x;
              vga_y      <= a.y;
              vga_colour <= a.colour;
              vga_plot   <= 1'b1;
            end
          end else if (grant_b) begin
            last_was_b <= 1'b1;
            if (b_in_range) begin
              vga_x      <= b.x;
              vga_y      <= b.y;
              vga_colour <= b.colour;
              vga_plot   <= 1'b1;
            end
          end
          // A requester pixel accepted in this same cycle is still written
          // above, so it lands one cycle before the first clear pixel.
          if (clear_req) begin
            clr_colour <= clear_colour;
            cnt_x      <= '0;
            cnt_y      <= '0;
            clear_busy <= 1'b1;
            state      <= CLEAR;
          end
        end
        CLEAR: begin
          vga_x      <= cnt_x;
          vga_y      <= cnt_y;
          vga_colour <= clr_colour;
          vga_plot   <= 1'b1;
          if (cnt_x == X_LAST) begin
            cnt_x <= '0;
            if (cnt_y == Y_LAST) begin
              cnt_y      <= '0;
              clear_busy <= 1'b0;
              state      <= IDLE;
            end else begin
              cnt_y <= cnt_y + 1'b1;
            end
          end else begin
            cnt_x <= cnt_x + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed self-checking bench for vga_plot_arbiter: reset state, single and
// contended requests, full-screen clear, off-screen pixels and reset mid-clear.
module tb_vga_plot_arbiter;

  logic       clock;
  logic       reset;
  logic       clear_req;
  logic [2:0] clear_colour;
  logic       clear_busy;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  int errors;
  int checks;

  vga_plot_arbiter_if #(.X_W(8), .Y_W(7), .C_W(3)) ia ();
  vga_plot_arbiter_if #(.X_W(8), .Y_W(7), .C_W(3)) ib ();

  vga_plot_arbiter #(
    .X_W(8), .Y_W(7), .C_W(3), .X_MAX(159), .Y_MAX(119)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .clear_req    (clear_req),
    .clear_colour (clear_colour),
    .clear_busy   (clear_busy),
    .a            (ia.slave),
    .b            (ib.slave),
    .vga_x        (vga_x),
    .vga_y        (vga_y),
    .vga_colour   (vga_colour),
    .vga_plot     (vga_plot)
  );

  // Free-running 100 MHz-style bench clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(
    input logic av, input logic [7:0] ax, input logic [6:0] ay, input logic [2:0] ac,
    input logic bv, input logic [7:0] bx, input logic [6:0] by, input logic [2:0] bc,
    input logic cr, input logic [2:0] cc);
    ia.valid     = av;
    ia.x         = ax;
    ia.y         = ay;
    ia.colour    = ac;
    ib.valid     = bv;
    ib.x         = bx;
    ib.y         = by;
    ib.colour    = bc;
    clear_req    = cr;
    clear_colour = cc;
  endtask

  // Walks n clear pixels starting at the negedge where pixel 0 is shown.
  task automatic verifyClear(input logic [2:0] col, input logic a_pend, input int n);
    for (int k = 0; k < n; k++) begin
      logic [20:0] exp_v;
      exp_v = {1'b1, 8'(k % 160), 7'(k / 160), col, (k != 19199), (a_pend && (k == 19199))};
      checkOutput("clear_pixel",
                  {11'b0, vga_plot, vga_x, vga_y, vga_colour, clear_busy, ia.ready},
                  {11'b0, exp_v});
      @(negedge clock);
    end
  endtask

  // Output snapshot {plot, x, y, colour, busy} for compact comparisons.
  function automatic logic [31:0] snap();
    return {12'b0, vga_plot, vga_x, vga_y, vga_colour, clear_busy};
  endfunction

  function automatic logic [31:0] pix(input logic p, input logic [7:0] x, input logic [6:0] y,
                                      input logic [2:0] c, input logic busy);
    return {12'b0, p, x, y, c, busy};
  endfunction

  // Directed test sequence.
  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    applyStimulus(1, 3, 3, 3, 1, 4, 4, 4, 0, 0);
    repeat (3) @(negedge clock);
    #1;
    checkOutput("rst_a_ready", 32'(ia.ready), 32'd0);
    checkOutput("rst_b_ready", 32'(ib.ready), 32'd0);
    checkOutput("rst_outputs", snap(), pix(0, 0, 0, 0, 0));

    // A alone
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(1, 10, 10, 7, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("a_only_a_ready", 32'(ia.ready), 32'd1);
    checkOutput("a_only_b_ready", 32'(ib.ready), 32'd0);
    @(negedge clock);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("a_only_plot", snap(), pix(1, 10, 10, 7, 0));
    checkOutput("a_only_b_ready2", 32'(ib.ready), 32'd0);
    @(negedge clock);
    checkOutput("a_only_hold", snap(), pix(0, 10, 10, 7, 0));

    // Contention after reset: A first, then alternating
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 1, 1, 1, 2, 2, 2, 0, 0);
      #1;
      checkOutput("rr_a_ready", 32'(ia.ready), 32'((i % 2) == 0));
      checkOutput("rr_b_ready", 32'(ib.ready), 32'((i % 2) == 1));
      if (i > 0) begin
        if ((i % 2) == 1) checkOutput("rr_plot", snap(), pix(1, 1, 1, 1, 0));
        else              checkOutput("rr_plot", snap(), pix(1, 2, 2, 2, 0));
      end
      @(negedge clock);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("rr_plot_last", snap(), pix(1, 2, 2, 2, 0));
    @(negedge clock);
    checkOutput("rr_idle", snap(), pix(0, 2, 2, 2, 0));

    // Clear requested while A has a pixel: A first, then the full frame
    applyStimulus(1, 5, 6, 2, 0, 0, 0, 0, 1, 1);
    #1;
    checkOutput("clr_a_ready", 32'(ia.ready), 32'd1);
    @(negedge clock);
    applyStimulus(1, 5, 6, 2, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("clr_a_pixel", snap(), pix(1, 5, 6, 2, 1));
    checkOutput("clr_a_blocked", 32'(ia.ready), 32'd0);
    @(negedge clock);
    verifyClear(3'd1, 1'b1, 19200);
    checkOutput("clr_a_again", snap(), pix(1, 5, 6, 2, 0));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    @(negedge clock);
    checkOutput("clr_after", snap(), pix(0, 5, 6, 2, 0));

    // Off-screen x: accepted, not plotted, pointer still advances to A
    applyStimulus(1, 160, 5, 4, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("oor_x_ready", 32'(ia.ready), 32'd1);
    @(negedge clock);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("oor_x_noplot", snap(), pix(0, 5, 6, 2, 0));
    applyStimulus(1, 1, 1, 1, 1, 20, 21, 5, 0, 0);
    #1;
    checkOutput("oor_rr_a_ready", 32'(ia.ready), 32'd0);
    checkOutput("oor_rr_b_ready", 32'(ib.ready), 32'd1);
    @(negedge clock);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("oor_rr_plot", snap(), pix(1, 20, 21, 5, 0));
    // Off-screen y
    applyStimulus(1, 0, 120, 3, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("oor_y_ready", 32'(ia.ready), 32'd1);
    @(negedge clock);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("oor_y_noplot", snap(), pix(0, 20, 21, 5, 0));

    // Clear interrupted by reset at pixel 500, then a fresh full clear
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 6);
    @(negedge clock);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("rc_start", snap(), pix(0, 20, 21, 5, 1));
    @(negedge clock);
    verifyClear(3'd6, 1'b0, 500);
    checkOutput("rc_pixel500", snap(), pix(1, 20, 3, 6, 1));
    reset = 1'b1;
    applyStimulus(1, 7, 7, 7, 1, 8, 8, 8, 1, 3);
    #1;
    checkOutput("rc_rst_a_ready", 32'(ia.ready), 32'd0);
    checkOutput("rc_rst_b_ready", 32'(ib.ready), 32'd0);
    @(negedge clock);
    checkOutput("rc_rst_outputs", snap(), pix(0, 0, 0, 0, 0));
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 6);
    @(negedge clock);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("rc_restart", snap(), pix(0, 0, 0, 0, 1));
    @(negedge clock);
    verifyClear(3'd6, 1'b0, 19200);
    checkOutput("rc_done", snap(), pix(0, 159, 119, 6, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
